// File: rtl/hpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpu_pkg
// Description : Shared types and constants for the HPU job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hpu_pkg;

    // Default widths for item-memory address and loop limits
    localparam int c_mat_w = 16;
    localparam int c_i_w   = 20;
    localparam int c_j_w   = 20;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } hpu_state_e;

    // Control register bit positions (AXI-Lite side)
    localparam int c_ctrl_start_bit  = 0;
    localparam int c_ctrl_abort_bit  = 1;
    localparam int c_ctrl_skip_bit   = 2;

    // Status register bit positions (AXI-Lite side)
    localparam int c_stat_busy_bit    = 0;
    localparam int c_stat_done_bit    = 1;
    localparam int c_stat_aborted_bit = 2;

endpackage
`default_nettype wire

// File: rtl/hpu_nest_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hpu_nest_cnt
// Description : Two-level inclusive i/j loop counter. j runs 0..lim_j, then
//               wraps and advances i. On the final position i is held so the
//               counter never rolls over.
// Revision    : 1.0 - initial release
// ============================================================================
module hpu_nest_cnt
    import hpu_pkg::*;
#(
    parameter int I_W = c_i_w,
    parameter int J_W = c_j_w
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           inc,
    input  logic [I_W-1:0] lim_i,
    input  logic [J_W-1:0] lim_j,
    output logic           wrap_j,
    output logic           wrap_all
);

    localparam logic [I_W-1:0] c_i_one = {{(I_W-1){1'b0}}, 1'b1};
    localparam logic [J_W-1:0] c_j_one = {{(J_W-1){1'b0}}, 1'b1};

    logic [I_W-1:0] i_q, i_d;
    logic [J_W-1:0] j_q, j_d;

    // Wrap flags describe the current position, valid in the inc cycle
    always_comb begin
        wrap_j   = (j_q == lim_j);
        wrap_all = wrap_j && (i_q == lim_i);
    end

    // Next-count: clear, advance j, or wrap j and advance i (held at the end)
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (inc) begin
            if (wrap_j) begin
                j_d = '0;
                if (!wrap_all) begin
                    i_d = i_q + c_i_one;
                end
            end else begin
                j_d = j_q + c_j_one;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpu_run_seq.sv
`default_nettype none
// ============================================================================
// Module      : hpu_run_seq
// Description : Sequencer for one HPU job: item-memory fill, encode loop over
//               addr_i x addr_j input beats, then wait for the output stream's
//               last beat. Software only pulses start/abort and reads status.
// Revision    : 1.0 - initial release
// ============================================================================
module hpu_run_seq
    import hpu_pkg::*;
#(
    parameter int MAT_W = c_mat_w,
    parameter int I_W   = c_i_w,
    parameter int J_W   = c_j_w
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESETN,
    input  logic             start,
    input  logic             abort,
    input  logic             skip_init,
    input  logic [MAT_W-1:0] random_num,
    input  logic [I_W-1:0]   addr_i,
    input  logic [J_W-1:0]   addr_j,
    input  logic             get_valid,
    output logic             get_ready,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic             out_last,
    output logic             matw,
    output logic [MAT_W-1:0] mat_a,
    output logic             run,
    output logic             exec,
    output logic             update,
    output logic             get_fin,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [MAT_W-1:0] c_mat_one = {{(MAT_W-1){1'b0}}, 1'b1};

    hpu_state_e       state_q, state_d;
    logic [MAT_W-1:0] rn_q, rn_d;
    logic [I_W-1:0]   lim_i_q, lim_i_d;
    logic [J_W-1:0]   lim_j_q, lim_j_d;
    logic [MAT_W-1:0] mat_a_q, mat_a_d;
    logic             matw_q, matw_d;
    logic             run_q, run_d;
    logic             exec_q, exec_d;
    logic             update_q, update_d;
    logic             get_fin_q, get_fin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             wrap_j;
    logic             wrap_all;
    logic             beat;

    hpu_nest_cnt #(
        .I_W (I_W),
        .J_W (J_W)
    ) u_cnt (
        .clk      (AXIS_ACLK),
        .rst_n    (AXIS_ARESETN),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .lim_i    (lim_i_q),
        .lim_j    (lim_j_q),
        .wrap_j   (wrap_j),
        .wrap_all (wrap_all)
    );

    // Input stream is accepted only while in RUN; this is the one unregistered output
    always_comb begin
        get_ready = (state_q == ST_RUN);
        beat      = get_valid && get_ready;
    end

    // Next-state and registered-output logic; abort outranks everything outside IDLE
    always_comb begin
        state_d   = state_q;
        rn_d      = rn_q;
        lim_i_d   = lim_i_q;
        lim_j_d   = lim_j_q;
        mat_a_d   = mat_a_q;
        matw_d    = matw_q;
        run_d     = run_q;
        exec_d    = 1'b0;
        update_d  = 1'b0;
        get_fin_d = 1'b0;
        done_d    = done_q;
        aborted_d = aborted_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            matw_d    = 1'b0;
            mat_a_d   = '0;
            run_d     = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rn_d      = random_num;
                        lim_i_d   = addr_i;
                        lim_j_d   = addr_j;
                        done_d    = 1'b0;
                        aborted_d = 1'b0;
                        mat_a_d   = '0;
                        if (skip_init) begin
                            state_d = ST_ARM;
                            run_d   = 1'b1;
                        end else begin
                            state_d = ST_INIT;
                            matw_d  = 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    if (mat_a_q == rn_q) begin
                        state_d = ST_ARM;
                        matw_d  = 1'b0;
                        mat_a_d = '0;
                        run_d   = 1'b1;
                    end else begin
                        mat_a_d = mat_a_q + c_mat_one;
                    end
                end
                ST_ARM: begin
                    cnt_clr = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (beat) begin
                        cnt_inc  = 1'b1;
                        exec_d   = 1'b1;
                        update_d = wrap_j;
                        if (wrap_all) begin
                            get_fin_d = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state_d = ST_DONE;
                        run_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    matw_d  = 1'b0;
                    mat_a_d = '0;
                    run_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, shadow and output registers
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q   <= ST_IDLE;
            rn_q      <= '0;
            lim_i_q   <= '0;
            lim_j_q   <= '0;
            mat_a_q   <= '0;
            matw_q    <= 1'b0;
            run_q     <= 1'b0;
            exec_q    <= 1'b0;
            update_q  <= 1'b0;
            get_fin_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rn_q      <= rn_d;
            lim_i_q   <= lim_i_d;
            lim_j_q   <= lim_j_d;
            mat_a_q   <= mat_a_d;
            matw_q    <= matw_d;
            run_q     <= run_d;
            exec_q    <= exec_d;
            update_q  <= update_d;
            get_fin_q <= get_fin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Drive ports from their registers
    always_comb begin
        matw    = matw_q;
        mat_a   = mat_a_q;
        run     = run_q;
        exec    = exec_q;
        update  = update_q;
        get_fin = get_fin_q;
        busy    = busy_q;
        done    = done_q;
        aborted = aborted_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hpu_run_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpu_run_seq
// Description : Self-checking bench for hpu_run_seq. Strobe expectations are
//               queued when beats are driven and popped when exec appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpu_run_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        skip_init = 1'b0;
    logic [15:0] random_num = '0;
    logic [19:0] addr_i = '0;
    logic [19:0] addr_j = '0;
    logic        get_valid = 1'b0;
    logic        get_ready;
    logic        out_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_last = 1'b0;
    logic        matw;
    logic [15:0] mat_a;
    logic        run;
    logic        exec;
    logic        update;
    logic        get_fin;
    logic        busy;
    logic        done;
    logic        aborted;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit upd;
        bit fin;
    } exp_t;

    exp_t sb[$];

    hpu_run_seq #(
        .MAT_W (16),
        .I_W   (20),
        .J_W   (20)
    ) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rst_n),
        .start        (start),
        .abort        (abort),
        .skip_init    (skip_init),
        .random_num   (random_num),
        .addr_i       (addr_i),
        .addr_j       (addr_j),
        .get_valid    (get_valid),
        .get_ready    (get_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .matw         (matw),
        .mat_a        (mat_a),
        .run          (run),
        .exec         (exec),
        .update       (update),
        .get_fin      (get_fin),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every strobe cycle must match the oldest queued beat
    always @(negedge clk) begin
        if (rst_n && (exec || update || get_fin)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected cyc=%0d exec=%b update=%b get_fin=%b required none",
                         cyc, exec, update, get_fin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({exec, update, get_fin} !== {1'b1, e.upd, e.fin} || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe cyc=%0d exec/upd/fin=%b%b%b required cyc=%0d exec/upd/fin=1%b%b",
                             cyc, exec, update, get_fin, e.cyc, e.upd, e.fin);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a whole job; abort_after>=0 aborts after that many beats,
    // start_at>=0 pulses a stray start (with addr_j=5) at that RUN cycle.
    task automatic run_job(input int rn, input int ai, input int aj, input bit skip,
                           input int pat, input int drain_wait, input int abort_after,
                           input int start_at);
        int  beats;
        int  n;
        int  k;
        bit  v;
        exp_t e;
        beats = (ai + 1) * (aj + 1);
        random_num = 16'(rn);
        addr_i     = 20'(ai);
        addr_j     = 20'(aj);
        skip_init  = skip;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        random_num = 16'($urandom);
        addr_i     = 20'($urandom);
        addr_j     = 20'($urandom);
        skip_init  = ~skip;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL job_start busy/done/aborted=%b%b%b required 100", busy, done, aborted);
        end
        if (!skip) begin
            for (int m = 0; m <= rn; m++) begin
                total++;
                if (matw !== 1'b1 || mat_a !== 16'(m) || run !== 1'b0) begin
                    bad++;
                    $display("FAIL init_fill matw=%b mat_a=%0d run=%b required matw=1 mat_a=%0d run=0",
                             matw, mat_a, run, m);
                end
                tick();
            end
        end
        total++;
        if (matw !== 1'b0 || mat_a !== 16'd0 || run !== 1'b1 || get_ready !== 1'b0) begin
            bad++;
            $display("FAIL arm matw=%b mat_a=%0d run=%b get_ready=%b required 0 0 1 0",
                     matw, mat_a, run, get_ready);
        end
        tick();
        if (pat == 1) begin
            out_valid = 1'b1;
            out_ready = 1'b1;
            out_last  = 1'b1;
        end
        n = 0;
        k = 0;
        while (n < beats && k < 4 * beats + 10) begin
            if (abort_after >= 0 && n == abort_after) break;
            v = (pat == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
            total++;
            if (get_ready !== 1'b1 || run !== 1'b1) begin
                bad++;
                $display("FAIL run_ready get_ready=%b run=%b required 1 1 (beat %0d)", get_ready, run, n);
            end
            get_valid = v;
            if (start_at >= 0 && k == start_at) begin
                start  = 1'b1;
                addr_j = 20'd5;
            end
            if (v) begin
                e.cyc = cyc + 1;
                e.upd = ((n % (aj + 1)) == aj);
                e.fin = (n == beats - 1);
                sb.push_back(e);
                n++;
            end
            tick();
            start = 1'b0;
            k++;
        end
        get_valid = 1'b0;
        out_valid = 1'b0;
        out_ready = 1'b0;
        out_last  = 1'b0;
        if (abort_after >= 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            total++;
            if (busy !== 1'b0 || get_ready !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 ||
                run !== 1'b0 || matw !== 1'b0) begin
                bad++;
                $display("FAIL abort busy=%b get_ready=%b aborted=%b done=%b run=%b matw=%b required 0 0 1 0 0 0",
                         busy, get_ready, aborted, done, run, matw);
            end
            tick();
            total++;
            if (busy !== 1'b0 || exec !== 1'b0) begin
                bad++;
                $display("FAIL abort_settle busy=%b exec=%b required 0 0", busy, exec);
            end
            return;
        end
        total++;
        if (n != beats) begin
            bad++;
            $display("FAIL beat_budget beats=%0d required %0d", n, beats);
        end
        total++;
        if (get_ready !== 1'b0 || run !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drain get_ready=%b run=%b done=%b busy=%b required 0 1 0 1",
                     get_ready, run, done, busy);
        end
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_ready = 1'b0;
        for (int w = 0; w < drain_wait; w++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b1 || get_ready !== 1'b0) begin
                bad++;
                $display("FAIL drain_wait done=%b busy=%b get_ready=%b required 0 1 0",
                         done, busy, get_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_valid = 1'b0;
        out_ready = 1'b0;
        out_last  = 1'b0;
        total++;
        if (done !== 1'b1 || run !== 1'b0 || busy !== 1'b1 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL done_state done=%b run=%b busy=%b aborted=%b required 1 0 1 0",
                     done, run, busy, aborted);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL back_idle busy=%b done=%b required 0 1", busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({matw, run, exec, update, get_fin, busy, done, aborted, get_ready} !== 9'd0 ||
            mat_a !== 16'd0) begin
            bad++;
            $display("FAIL reset outs=%b mat_a=%0d required all 0",
                     {matw, run, exec, update, get_fin, busy, done, aborted, get_ready}, mat_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_and_run();
        run_job(3, 1, 2, 1'b0, 0, 4, -1, -1);
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || aborted !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle busy=%b aborted=%b done=%b required 0 0 1", busy, aborted, done);
        end
    endtask

    task automatic test_skip_single();
        run_job(5, 0, 0, 1'b1, 0, 0, -1, -1);
    endtask

    task automatic test_gaps();
        run_job(1, 1, 1, 1'b0, 1, 10, -1, -1);
    endtask

    task automatic test_abort();
        run_job(2, 299, 2, 1'b0, 0, 0, 4, -1);
        run_job(0, 299, 2, 1'b1, 0, 2, -1, -1);
    endtask

    task automatic test_reset_mid_init();
        random_num = 16'd20;
        skip_init  = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (matw !== 1'b1 || mat_a !== 16'd2) begin
            bad++;
            $display("FAIL mid_init matw=%b mat_a=%0d required 1 2", matw, mat_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (matw !== 1'b0 || mat_a !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset matw=%b mat_a=%0d busy=%b required 0 0 0", matw, mat_a, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || matw !== 1'b0 || run !== 1'b0) begin
            bad++;
            $display("FAIL post_reset busy=%b matw=%b run=%b required 0 0 0", busy, matw, run);
        end
    endtask

    task automatic test_start_while_busy();
        run_job(0, 1, 2, 1'b0, 0, 1, -1, 2);
    endtask

    initial begin
        test_reset();
        test_fill_and_run();
        test_abort_idle();
        test_skip_single();
        test_gaps();
        test_abort();
        test_reset_mid_init();
        test_start_while_busy();
        tick();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_strobes pending=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hpu_run_seq.md
Name: hpu_run_seq

Overview:
Sequencer for one HPU job. It drives the item-memory fill phase (matw/mat_a), then the encode phase (run, input-stream acceptance, exec/update/get_fin over an addr_i x addr_j loop). It waits for the output stream's last beat before reporting completion. It replaces the hand-written run/matw register writes: the AXI-Lite side only pulses start/abort and reads busy/done.

Parameters:
MAT_W, 16, width of item-memory address / random_num
I_W, 20, width of outer loop limit addr_i
J_W, 20, width of inner loop limit addr_j

Ports:
AXIS_ACLK  in  1  sole clock
AXIS_ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle job start request
abort  in  1  one-cycle job abort request
skip_init  in  1  1 = skip item-memory fill, sampled at start
random_num  in  MAT_W  last item-memory address (inclusive), sampled at start
addr_i  in  I_W  last outer index (inclusive), sampled at start
addr_j  in  J_W  last inner index (inclusive), sampled at start
get_valid  in  1  input stream TVALID
get_ready  out  1  input stream TREADY
out_valid  in  1  output stream TVALID (monitor)
out_ready  in  1  output stream TREADY (monitor)
out_last  in  1  output stream TLAST (monitor)
matw  out  1  item-memory write phase
mat_a  out  MAT_W  item-memory write address
run  out  1  encode phase active (IDLE/INIT = 0)
exec  out  1  accepted-beat strobe to core
update  out  1  end-of-item strobe to core
get_fin  out  1  one-cycle pulse: all input consumed
busy  out  1  state != IDLE
done  out  1  sticky job-complete flag
aborted  out  1  sticky job-aborted flag

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; mat_a=0; internal counters 0.
- States: IDLE, INIT, ARM, RUN, DRAIN, DONE. All outputs are registered except get_ready = (state==RUN).
- IDLE: on start, latch skip_init, random_num, addr_i and addr_j into shadow regs. Clear done and aborted. Go to INIT, or to ARM if skip_init=1.
- INIT: matw=1. mat_a starts at 0 and increments by 1 per cycle. On the cycle mat_a==random_num, go to ARM. matw is high for exactly random_num+1 cycles, then matw=0 and mat_a=0.
- ARM: one cycle. Clear the i and j counters. Set run=1 (it stays 1 through DRAIN).
- RUN:
  - A beat is get_valid & get_ready.
  - exec=1 exactly one cycle after each beat.
  - On a beat: if j==addr_j, set j=0, pulse update one cycle after the beat, and i++; otherwise j++.
  - Beat with i==addr_i & j==addr_j: get_fin=1 next cycle, go to DRAIN (get_ready drops next cycle).
  - No beat: counters hold; exec and update stay 0.
- DRAIN: on out_valid & out_ready & out_last, go to DONE. Wait indefinitely otherwise.
- DONE: one cycle. run=0; done set (sticky until next accepted start); go to IDLE.
- Total beats per job = (addr_i+1)*(addr_j+1). Counters never wrap. The limits are inclusive; all-zero limits give 1 beat.
- abort, any non-IDLE state:
  - Next cycle: state=IDLE; matw, run, exec, update and get_fin = 0; aborted=1; done unchanged.
  - abort has priority over every other transition in the same cycle.
  - abort in IDLE: no effect.
- start while busy: ignored; shadow regs unchanged. start & abort together in IDLE: start wins.
- Input changes to random_num, addr_i, addr_j or skip_init after start: no effect on the running job.
- out_last handshake seen outside DRAIN: ignored.

Decomposition:
- hpu_pkg:
  - state enum (6 states, 3-bit encoding)
  - MAT_W, I_W, J_W default constants
  - control-register bit positions: start=0, abort=1, skip_init=2; status busy=0, done=1, aborted=2
- Sub-module hpu_nest_cnt: two-level inclusive i/j counter.
  - Inputs: clr, inc, lim_i, lim_j.
  - Outputs: wrap_j and wrap_all (combinational, valid in the inc cycle).
  - The FSM and strobe pipeline live in hpu_run_seq.

Test Plan:
1. random_num=3, addr_i=1, addr_j=2, get_valid held 1 -> matw high 4 cycles with mat_a 0,1,2,3; then run=1. Then 6 beats: exec 6 pulses; update after beats 3 and 6; get_fin after beat 6. Out_last handshake 5 cycles later -> done=1, busy=0.
2. skip_init=1, addr_i=0, addr_j=0 -> matw never high; ARM then 1 beat; update and get_fin on the same cycle.
3. get_valid toggling 1,0,0,1 and out_ready low for 10 DRAIN cycles -> counters hold in gaps; exec only on beats; done only after the out_last handshake.
4. abort after 4 of 900 beats (addr_i=299, addr_j=2) -> next cycle idle, get_ready=0, aborted=1, done=0. A new start then runs all 900 beats cleanly.
5. AXIS_ARESETN asserted mid-INIT with no clock edge -> matw and mat_a go to 0 immediately. After release, state is IDLE.
6. start pulsed during RUN with addr_j changed to 5 -> ignored; the job completes with the original beat count.
